// File: rtl/bram_arbiter2_pkg.sv
// Shared constants and types for the two-port round-robin block RAM arbiter.
package bram_arbiter2_pkg;

  localparam int AW_C       = 11;
  localparam int DW_C       = 8;
  localparam int CLEAR_LAST = 2047;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/bram_port8.sv
// Port A of a RAMB16BWER in 9-bit mode (parity unused, port B tied off): byte
// address a sits on ADDRA[13:3], write-first, one-cycle read, INIT byte a = a[7:0].
module bram_port8 #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    wea_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  // Cells hold data XOR the low address byte, so all-zero power-up contents
  // read back as the INIT pattern.
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] dout_q;
  logic [DW-1:0] tag;

  assign tag = DW'(addr_i);

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (|wea_i) begin
        mem_q[addr_i] <= wdata_i ^ tag;
        dout_q        <= wdata_i;
      end else begin
        dout_q <= mem_q[addr_i] ^ tag;
      end
    end
  end

  assign rdata_o = dout_q;

endmodule

// File: rtl/bram_arbiter2.sv
// Round-robin arbiter sharing one 2048x8 block RAM port between two requesters.
// Define BRAM_ARBITER2_CLEAR_EN to zero-fill the RAM after reset before any grant.
module bram_arbiter2
  import bram_arbiter2_pkg::*;
#(
  parameter int AW = AW_C,
  parameter int DW = DW_C
) (
  input  logic          CLKIN,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY
);

  logic          run;
  logic          clearing;
  logic [AW-1:0] clr_addr;

`ifdef BRAM_ARBITER2_CLEAR_EN
  state_e        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == ST_CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == AW'(CLEAR_LAST)) begin
        state_d = ST_RUN;
      end
    end
  end

  assign clearing = (state_q == ST_CLEAR);
  assign run      = (state_q == ST_RUN);
  assign clr_addr = clr_q;
`else
  assign clearing = 1'b0;
  assign run      = 1'b1;
  assign clr_addr = '0;
`endif

  assign BUSY = clearing;

  // Pointer names the requester favoured on a tie.
  req_idx_t ptr_q, ptr_d;
  logic     gnt0, gnt1;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (run) begin
      if (REQ0 && REQ1) begin
        gnt0 = (ptr_q == 1'b0);
        gnt1 = (ptr_q == 1'b1);
      end else begin
        gnt0 = REQ0;
        gnt1 = REQ1;
      end
      if (gnt0) ptr_d = 1'b1;
      if (gnt1) ptr_d = 1'b0;
    end
  end

  assign GNT0 = gnt0;
  assign GNT1 = gnt1;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ADDR0;
    ram_wdata = WDATA0;
    if (clearing) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = '0;
    end else if (gnt0) begin
      ram_en = 1'b1;
      ram_we = WE0;
    end else if (gnt1) begin
      ram_en    = 1'b1;
      ram_we    = WE1;
      ram_addr  = ADDR1;
      ram_wdata = WDATA1;
    end
  end

  bram_port8 #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk_i   (CLKIN),
    .en_i    (ram_en),
    .wea_i   ({4{ram_we}}),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic [DW-1:0] hold_q, hold_d;

  assign rv0_d  = gnt0 & ~WE0;
  assign rv1_d  = gnt1 & ~WE1;
  // RAM output moves on writes (write-first), so the last read result is held.
  assign hold_d = (rv0_q | rv1_q) ? ram_rdata : hold_q;

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      ptr_q  <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
      hold_q <= hold_d;
    end
  end

  assign RVALID0 = rv0_q;
  assign RVALID1 = rv1_q;
  assign RDATA   = (rv0_q | rv1_q) ? ram_rdata : hold_q;

endmodule

// File: tb/tb_bram_arbiter2.sv
// Directed vector bench for bram_arbiter2; the clear sequence is exercised when
// BRAM_ARBITER2_CLEAR_EN is defined, the INIT-content table otherwise.
module tb_bram_arbiter2;

  logic        CLKIN = 1'b0;
  logic        RESET, REQ0, REQ1, WE0, WE1;
  logic [10:0] ADDR0, ADDR1;
  logic [7:0]  WDATA0, WDATA1;
  logic        GNT0, GNT1, RVALID0, RVALID1, BUSY;
  logic [7:0]  RDATA;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLKIN = ~CLKIN;

  bram_arbiter2 dut (
    .CLKIN   (CLKIN),
    .RESET   (RESET),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .WE0     (WE0),
    .WE1     (WE1),
    .ADDR0   (ADDR0),
    .ADDR1   (ADDR1),
    .WDATA0  (WDATA0),
    .WDATA1  (WDATA1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .RVALID0 (RVALID0),
    .RVALID1 (RVALID1),
    .RDATA   (RDATA),
    .BUSY    (BUSY)
  );

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [10:0] a0;
    logic [7:0]  d0;
    logic        r1, w1;
    logic [10:0] a1;
    logic [7:0]  d1;
    logic        g0, g1, v0, v1;
    logic [7:0]  rd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [10:0] a0, logic [7:0] d0,
                              logic r1, logic w1, logic [10:0] a1, logic [7:0] d1,
                              logic g0, logic g1, logic v0, logic v1, logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input int row, input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RESET = v.rst;
    REQ0 = v.r0; WE0 = v.w0; ADDR0 = v.a0; WDATA0 = v.d0;
    REQ1 = v.r1; WE1 = v.w1; ADDR1 = v.a1; WDATA1 = v.d1;
  endtask

  vec_t tv[25];
  vec_t idle;

  initial begin
    idle = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,0,0,8'h00);
    drive(idle);
    RESET = 1'b1;
    @(posedge CLKIN);
    @(posedge CLKIN);
    #1;

`ifdef BRAM_ARBITER2_CLEAR_EN
    begin
      vec_t v;
      int   busy_bad;
      int   gnt_bad;
      v = mk(0, 0,0,11'h000,8'h00, 1,0,11'h7FF,8'h00, 0,0,0,0,8'h00);
      drive(v);
      busy_bad = 0;
      gnt_bad  = 0;
      for (int c = 0; c < 2048; c++) begin
        #3;
        if (BUSY !== 1'b1) busy_bad++;
        if (GNT0 !== 1'b0 || GNT1 !== 1'b0) gnt_bad++;
        @(posedge CLKIN);
        #1;
      end
      chk(0, "busy_cycles_bad", 8'(busy_bad), 8'd0);
      chk(0, "gnt_during_clear", 8'(gnt_bad), 8'd0);
      #3;
      chk(1, "busy_fall", {7'd0, BUSY}, 8'd0);
      chk(1, "gnt1_first", {7'd0, GNT1}, 8'd1);
      chk(1, "gnt0_first", {7'd0, GNT0}, 8'd0);
      @(posedge CLKIN);
      #1;
      drive(idle);
      #3;
      chk(2, "rvalid1", {7'd0, RVALID1}, 8'd1);
      chk(2, "rvalid0", {7'd0, RVALID0}, 8'd0);
      chk(2, "rdata_cleared", RDATA, 8'h00);
      chk(2, "busy", {7'd0, BUSY}, 8'd0);
    end
`else
    //             rst r0 w0 a0      d0     r1 w1 a1      d1     g0 g1 v0 v1 rd
    tv[0]  = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,0,0,8'h00);
    tv[1]  = mk(0, 1,0,11'h005,8'h00, 0,0,11'h000,8'h00, 1,0,0,0,8'h00);
    tv[2]  = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,1,0,8'h05);
    tv[3]  = mk(0, 1,1,11'h010,8'hA5, 0,0,11'h000,8'h00, 1,0,0,0,8'h05);
    tv[4]  = mk(0, 0,0,11'h000,8'h00, 1,0,11'h010,8'h00, 0,1,0,0,8'h05);
    tv[5]  = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,0,1,8'hA5);
    tv[6]  = mk(0, 1,0,11'h001,8'h00, 1,0,11'h002,8'h00, 1,0,0,0,8'hA5);
    tv[7]  = mk(0, 1,0,11'h001,8'h00, 1,0,11'h002,8'h00, 0,1,1,0,8'h01);
    tv[8]  = mk(0, 1,0,11'h001,8'h00, 1,0,11'h002,8'h00, 1,0,0,1,8'h02);
    tv[9]  = mk(0, 1,0,11'h001,8'h00, 1,0,11'h002,8'h00, 0,1,1,0,8'h01);
    tv[10] = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,0,1,8'h02);
    tv[11] = mk(0, 1,0,11'h0FF,8'h00, 0,0,11'h000,8'h00, 1,0,0,0,8'h02);
    tv[12] = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,1,0,8'hFF);
    tv[13] = mk(0, 0,0,11'h000,8'h00, 1,0,11'h003,8'h00, 0,1,0,0,8'hFF);
    tv[14] = mk(0, 0,0,11'h000,8'h00, 1,1,11'h003,8'h3C, 0,1,0,1,8'h03);
    tv[15] = mk(0, 1,0,11'h003,8'h00, 1,0,11'h004,8'h00, 1,0,0,0,8'h03);
    tv[16] = mk(0, 0,0,11'h000,8'h00, 1,0,11'h004,8'h00, 0,1,1,0,8'h3C);
    tv[17] = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,0,1,8'h04);
    tv[18] = mk(0, 1,0,11'h007,8'h00, 0,0,11'h000,8'h00, 1,0,0,0,8'h04);
    tv[19] = mk(1, 1,0,11'h008,8'h00, 0,0,11'h000,8'h00, 1,0,1,0,8'h07);
    tv[20] = mk(0, 1,0,11'h001,8'h00, 1,0,11'h002,8'h00, 1,0,0,0,8'h00);
    tv[21] = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,1,0,8'h01);
    tv[22] = mk(0, 0,0,11'h000,8'h00, 1,1,11'h0FF,8'h11, 0,1,0,0,8'h01);
    tv[23] = mk(0, 0,0,11'h000,8'h00, 1,0,11'h0FF,8'h00, 0,1,0,0,8'h01);
    tv[24] = mk(0, 0,0,11'h000,8'h00, 0,0,11'h000,8'h00, 0,0,0,1,8'h11);

    for (int i = 0; i < 25; i++) begin
      drive(tv[i]);
      #3;
      chk(i, "GNT0",    {7'd0, GNT0},    {7'd0, tv[i].g0});
      chk(i, "GNT1",    {7'd0, GNT1},    {7'd0, tv[i].g1});
      chk(i, "RVALID0", {7'd0, RVALID0}, {7'd0, tv[i].v0});
      chk(i, "RVALID1", {7'd0, RVALID1}, {7'd0, tv[i].v1});
      chk(i, "RDATA",   RDATA,           tv[i].rd);
      chk(i, "BUSY",    {7'd0, BUSY},    8'd0);
      @(posedge CLKIN);
      #1;
    end
`endif

    drive(idle);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
